// File: rtl/rvx_dm_responder_pkg.sv
// Shared types and helpers for the RVX data-memory responder.
// Bus width, lane count, sweep FSM states and a byte-lane merge helper.
package rvx_dm_responder_pkg;

  localparam int BUS_W = 32;
  localparam int LANES = BUS_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmState_t;

  function automatic logic [BUS_W-1:0] laneMerge(
    input logic [BUS_W-1:0] oldW,
    input logic [BUS_W-1:0] newW,
    input logic [LANES-1:0] strb
  );
    logic [BUS_W-1:0] r;
    r = oldW;
    for (int i = 0; i < LANES; i++)
      if (strb[i]) r[8*i +: 8] = newW[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/rvx_dm_responder_if.sv
// CPU data-memory port bundle.
// master = CPU side (drives address/enables/strobes/data), slave = responder.
interface rvx_dm_responder_if;
  import rvx_dm_responder_pkg::*;

  logic [BUS_W-1:0] dmAddrIn;
  logic             dmWeIn;
  logic             dmReIn;
  logic [LANES-1:0] dmDataWIn;
  logic [BUS_W-1:0] dmWDataIn;
  logic [BUS_W-1:0] dmRDataOut;
  logic             busyOut;
  logic             errOut;

  modport master (
    output dmAddrIn, dmWeIn, dmReIn,
    output dmDataWIn, dmWDataIn,
    input  dmRDataOut, busyOut, errOut
  );

  modport slave (
    input  dmAddrIn, dmWeIn, dmReIn,
    input  dmDataWIn, dmWDataIn,
    output dmRDataOut, busyOut, errOut
  );

endinterface

// File: rtl/rvx_dm_sram.sv
// DEPTH x 32 word RAM, per-byte write enables, registered write-first read.
// Ports: clk, rst (read register only), we/idx/wData, re, rClr, rData.
module rvx_dm_sram
  import rvx_dm_responder_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANES-1:0]  we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [BUS_W-1:0]  wData,
  input  logic              re,
  input  logic              rClr,
  output logic [BUS_W-1:0]  rData
);

  logic [BUS_W-1:0] mem [DEPTH];
  logic [BUS_W-1:0] merged;

  // Read and write share one index, so write-first is a lane merge.
  assign merged = laneMerge(mem[idx], wData, we);

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (we[i]) mem[idx][8*i +: 8] <= wData[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rData <= '0;
    else if (rClr) rData <= '0;
    else if (re)   rData <= merged;
  end

endmodule

// File: rtl/rvx_dm_responder.sv
// Data-memory responder: address decode, sticky range error, busy, RAM.
// Ports: clk, rst (async, active-high), dm (slave modport of the dm bundle).
// Optional RVX_DM_CLEAR_EN: zero-fill sweep of the RAM after reset.
module rvx_dm_responder
  import rvx_dm_responder_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  rvx_dm_responder_if.slave dm
);

  localparam logic [32:0] SPAN = 33'(longint'(DEPTH) * 4);

  logic [31:0]       off;
  logic [ADDR_W-1:0] idx;
  logic              inRange;
  logic              busy;
  logic [LANES-1:0]  accWe;
  logic              rdEn;
  logic              rdClr;
  logic              err;
  logic [LANES-1:0]  memWe;
  logic [ADDR_W-1:0] memIdx;
  logic [BUS_W-1:0]  memWData;
  logic [BUS_W-1:0]  rData;
  logic              unusedBits;

  assign off = dm.dmAddrIn - BASE_ADDR;
  assign idx = off[ADDR_W+1:2];
  // Compare the offset rather than BASE+SPAN so the top of memory can't wrap.
  assign inRange = (dm.dmAddrIn >= BASE_ADDR)
                && ({1'b0, off} < SPAN);
  assign unusedBits = ^{off[1:0], off[31:ADDR_W+2]};

  assign accWe = (dm.dmWeIn && !busy && inRange)
               ? dm.dmDataWIn : '0;
  assign rdEn  = dm.dmReIn && !busy && inRange;
  assign rdClr = dm.dmReIn && !rdEn;

`ifdef RVX_DM_CLEAR_EN
  dmState_t          state;
  dmState_t          stateNext;
  logic [ADDR_W-1:0] clrIdx;
  logic [ADDR_W-1:0] clrIdxNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= CLEAR;
      clrIdx <= '0;
    end else begin
      state  <= stateNext;
      clrIdx <= clrIdxNext;
    end
  end

  always_comb begin
    stateNext  = state;
    clrIdxNext = clrIdx;
    busy       = 1'b0;
    unique case (state)
      CLEAR: begin
        busy       = 1'b1;
        clrIdxNext = clrIdx + 1'b1;
        if (clrIdx == ADDR_W'(DEPTH - 1))
          stateNext = READY;
      end
      READY: ;
      default: ;
    endcase
  end

  // The sweep owns the RAM port while busy; CPU accesses are blocked then.
  assign memWe    = busy ? '1 : accWe;
  assign memIdx   = busy ? clrIdx : idx;
  assign memWData = busy ? '0 : dm.dmWDataIn;
`else
  assign busy     = 1'b0;
  assign memWe    = accWe;
  assign memIdx   = idx;
  assign memWData = dm.dmWDataIn;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if ((dm.dmWeIn || dm.dmReIn) && !busy && !inRange)
      err <= 1'b1;
  end

  rvx_dm_sram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) uSram (
    .clk   (clk),
    .rst   (rst),
    .we    (memWe),
    .idx   (memIdx),
    .wData (memWData),
    .re    (rdEn),
    .rClr  (rdClr),
    .rData (rData)
  );

  assign dm.dmRDataOut = rData;
  assign dm.busyOut    = busy;
  assign dm.errOut     = err;

endmodule

// File: tb/tb_rvx_dm_responder.sv
// Self-checking bench for rvx_dm_responder (directed + random vs. model).
// Build with or without +define+RVX_DM_CLEAR_EN.
module tb_rvx_dm_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mMem [DEPTH];
  logic [31:0] mRd;
  logic        mErr;
  logic        mBusy;

  always #5 clk = ~clk;

  rvx_dm_responder_if dmIf ();

  rvx_dm_responder #(
    .DEPTH     (DEPTH),
    .ADDR_W    (10),
    .BASE_ADDR (BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dm  (dmIf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    dmIf.dmWeIn    = we;
    dmIf.dmReIn    = re;
    dmIf.dmAddrIn  = a;
    dmIf.dmDataWIn = s;
    dmIf.dmWDataIn = d;
  endtask

  // Reference: apply one access to the model word array.
  task automatic model(input logic we, input logic re, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    longint o;
    bit     inR;
    int     w;
    o   = longint'(a) - longint'(BASE);
    inR = (o >= 0) && (o < DEPTH * 4);
    w   = int'(o / 4);
    if (mBusy) begin
      if (re) mRd = 32'h0;
      return;
    end
    if (we && inR)
      for (int i = 0; i < 4; i++)
        if (s[i]) mMem[w][8*i +: 8] = d[8*i +: 8];
    if (re) mRd = inR ? mMem[w] : 32'h0;
    if ((we || re) && !inR) mErr = 1'b1;
  endtask

  // Called just after a negedge: one access over the next posedge.
  task automatic step(input string tag, input logic we, input logic re,
                      input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d);
    drive(we, re, a, s, d);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    model(we, re, a, s, d);
    chk({tag, ".rd"}, dmIf.dmRDataOut, mRd);
    chk({tag, ".err"}, {31'h0, dmIf.errOut}, {31'h0, mErr});
    chk({tag, ".busy"}, {31'h0, dmIf.busyOut}, {31'h0, mBusy});
  endtask

  // Count busy cycles from reset release; optionally re-assert rst at abortAt.
  task automatic sweep(input int abortAt, output int n);
    n = 0;
    while (dmIf.busyOut === 1'b1 && n < 3000) begin
      if (n == abortAt) begin
        rst = 1'b1;
        return;
      end
      if (n == 10) drive(1'b1, 1'b0, 32'h4, 4'hF, 32'hFFFF_FFFF);
      if (n == 11) drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic doReset();
    int n;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    mRd  = 32'h0;
    mErr = 1'b0;
`ifdef RVX_DM_CLEAR_EN
    mBusy = 1'b1;
`else
    mBusy = 1'b0;
`endif
    chk("rst.rd", dmIf.dmRDataOut, 32'h0);
    chk("rst.err", {31'h0, dmIf.errOut}, 32'h0);
    chk("rst.busy", {31'h0, dmIf.busyOut}, {31'h0, mBusy});
    rst = 1'b0;
    #1;
`ifdef RVX_DM_CLEAR_EN
    sweep(-1, n);
    chk("busyLen", n, DEPTH);
    mBusy = 1'b0;
    for (int i = 0; i < DEPTH; i++) mMem[i] = 32'h0;
`else
    n = 0;
    chk("busyNone", {31'h0, dmIf.busyOut}, 32'h0);
`endif
    @(negedge clk);
  endtask

  initial begin
    int          n;
    logic [31:0] a;
    logic        we;
    logic        re;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) mMem[i] = 32'h0;
    doReset();

`ifdef RVX_DM_CLEAR_EN
    step("swDrop", 1'b0, 1'b1, 32'h4, 4'h0, 32'h0);
    chk("swDrop.lit", dmIf.dmRDataOut, 32'h0);
    step("swFFC", 1'b0, 1'b1, 32'hFFC, 4'h0, 32'h0);
    chk("swFFC.lit", dmIf.dmRDataOut, 32'h0);
    // Reset mid-sweep must restart the full-length sweep.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    sweep(500, n);
    chk("abortAt", n, 500);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    sweep(-1, n);
    chk("busyLen2", n, DEPTH);
    @(negedge clk);
`else
    step("c1w", 1'b1, 1'b0, 32'h8, 4'hF, 32'hCAFE_F00D);
    step("c1r", 1'b0, 1'b1, 32'h8, 4'h0, 32'h0);
    chk("c1.lit", dmIf.dmRDataOut, 32'hCAFE_F00D);
`endif

    step("t1w", 1'b1, 1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF);
    step("t1r", 1'b0, 1'b1, 32'h10, 4'h0, 32'h0);
    chk("t1.lit", dmIf.dmRDataOut, 32'hDEAD_BEEF);

    step("t2a", 1'b1, 1'b0, 32'h20, 4'hF, 32'hAABB_CCDD);
    step("t2b", 1'b1, 1'b0, 32'h20, 4'h1, 32'h0000_0011);
    step("t2r", 1'b0, 1'b1, 32'h20, 4'h0, 32'h0);
    chk("t2.lit", dmIf.dmRDataOut, 32'hAABB_CC11);
    step("t2c", 1'b1, 1'b0, 32'h20, 4'hC, 32'h5566_0000);
    step("t2nop", 1'b1, 1'b0, 32'h20, 4'h0, 32'hFFFF_FFFF);
    step("t2r2", 1'b0, 1'b1, 32'h22, 4'h0, 32'h0);
    chk("t2.lit2", dmIf.dmRDataOut, 32'h5566_CC11);
    step("hold", 1'b0, 1'b0, 32'h10, 4'h0, 32'h0);

    step("t3wr", 1'b1, 1'b1, 32'h30, 4'hF, 32'h1234_5678);
    chk("t3.lit", dmIf.dmRDataOut, 32'h1234_5678);

    // Random in-range traffic over a 16-word window, prefilled first.
    for (int i = 0; i < 16; i++)
      step("pre", 1'b1, 1'b0, 32'h100 + 32'(i * 4), 4'hF, $urandom);
    for (int i = 0; i < 400; i++) begin
      a  = 32'h100 + 32'($urandom_range(0, 15) * 4)
         + 32'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      step("rnd", we, re, a, 4'($urandom_range(0, 15)), $urandom);
    end

    step("oor", 1'b0, 1'b1, BASE + 32'(DEPTH * 4), 4'h0, 32'h0);
    chk("oor.rd", dmIf.dmRDataOut, 32'h0);
    chk("oor.err", {31'h0, dmIf.errOut}, 32'h1);
    step("oorW", 1'b1, 1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0BAD_0BAD);
    step("t4w", 1'b1, 1'b0, 32'h04, 4'hF, 32'h0F0F_A5A5);
    step("t4r", 1'b0, 1'b1, 32'h04, 4'h0, 32'h0);
    chk("t4.lit", dmIf.dmRDataOut, 32'h0F0F_A5A5);
    chk("t4.err", {31'h0, dmIf.errOut}, 32'h1);

    doReset();
    chk("clr.err", {31'h0, dmIf.errOut}, 32'h0);
    step("nopErr", 1'b1, 1'b0, BASE + 32'(DEPTH * 4), 4'h0, 32'h0);
    chk("nop.err", {31'h0, dmIf.errOut}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvx_dm_responder.md
Name: rvx_dm_responder

Overview:
Data-memory responder for the RVX CPU core. It is the slave end of the CPU's dm port, where the core drives address, read/write enables, byte strobes and write data. The block holds a word-organised RAM and applies byte-lane writes. It returns read data one cycle later and flags out-of-range accesses. It sits beside the CPU in the RVX_Aes top level, opposite Stage_MEM.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, minimum 4
ADDR_W, 10, word-index width; must equal log2(DEPTH)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH*4

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
dmAddrIn  in  BUS_W  byte address from CPU
dmWeIn  in  1  write request, single-cycle
dmReIn  in  1  read request, single-cycle
dmDataWIn  in  4  byte-lane write strobes; bit i enables byte i (bits 8i+7:8i)
dmWDataIn  in  BUS_W  write data, lane-aligned by CPU
dmRDataOut  out  BUS_W  registered read data
busyOut  out  1  high while the responder ignores accesses
errOut  out  1  sticky out-of-range flag

Behaviour:
- One clock domain; asynchronous, active-high reset.
- Reset values: dmRDataOut=0, errOut=0, busyOut=1 with RVX_DM_CLEAR_EN and 0 without. RAM contents are not reset, except by the clear sweep.
- Address decode:
  - off = dmAddrIn - BASE_ADDR; idx = off[ADDR_W+1:2].
  - dmAddrIn[1:0] is ignored; the strobes alone select lanes.
  - In range iff BASE_ADDR <= dmAddrIn < BASE_ADDR + DEPTH*4, using unsigned 32-bit compare with no wrap.
- Write:
  - On the clk edge with dmWeIn=1, busyOut=0 and in range, each byte i with dmDataWIn[i]=1 is replaced by dmWDataIn byte i.
  - Bytes with a 0 strobe are unchanged. dmDataWIn=4'b0000 is a legal no-op and does not set errOut.
- Read:
  - With dmReIn=1, busyOut=0 and in range, dmRDataOut takes RAM[idx] at the next edge. Latency is 1 cycle.
  - dmRDataOut holds its last value while dmReIn=0.
- Simultaneous read and write, same idx: write-first; dmRDataOut returns the merged new word.
- Simultaneous read and write, different idx: both are performed.
- Out of range:
  - The write is dropped. A read loads dmRDataOut=0.
  - errOut is set at the next edge and stays set until rst. Only an asserted dmWeIn or dmReIn triggers it.
- Busy: while busyOut=1, writes are dropped, reads load 0, and errOut is not updated.

Optional Feature:
RVX_DM_CLEAR_EN
- Defined:
  - After rst deassertion the FSM sits in CLEAR, with a counter clrIdx running 0..DEPTH-1.
  - Each cycle RAM[clrIdx] is written with 0 and clrIdx increments.
  - After writing DEPTH-1 the FSM moves to READY and busyOut falls. busyOut is high for exactly DEPTH cycles after reset release.
  - Reset during CLEAR restarts the sweep at 0. READY is absorbing until rst.
- Undefined: there is no FSM or counter, busyOut is tied 0, and RAM starts uninitialised (X in simulation).

Decomposition:
- Shared header (RVX_Info.v) supplies BUS_W and the RVX_DM_CLEAR_EN define.
- FSM state encodings (CLEAR=1'b0, READY=1'b1) are localparams in the block.
- One sub-module, rvx_dm_sram: DEPTH x 32 array with 4 per-byte write enables and a synchronous write-first read port. The top level holds the decode, error, busy and sweep logic.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x10 with strobes 1111; read 0x10 -> dmRDataOut=0xDEADBEEF one cycle after dmReIn, errOut=0.
- Write 0xAABBCCDD to 0x20, then 0x00000011 with strobes 0001 to 0x20; read -> 0xAABBCC11. Repeat with strobes 1100 and data 0x55660000 -> 0x5566CC11.
- Same cycle: write 0x12345678 to 0x30 (strobes 1111) with a read of 0x30 -> next-cycle dmRDataOut=0x12345678.
- Read of BASE_ADDR+DEPTH*4 (0x1000 at defaults) -> dmRDataOut=0 and errOut=1. Then a valid write/read of 0x04 works, errOut stays 1, and rst clears it.
- With RVX_DM_CLEAR_EN:
  - busyOut is high for exactly 1024 cycles after reset.
  - A write during busy is dropped.
  - After busy, a read of any address (e.g. 0xFFC) -> 0.
  - Asserting rst at sweep cycle 500 -> busyOut stays high for a full 1024 cycles after release.
- Without RVX_DM_CLEAR_EN: busyOut=0 from reset; a write then read at cycle 1 succeeds.
